// File: rtl/rgb_word_packer.sv
// Packs a 24-bit RGB pixel stream into 32-bit AXI4-Stream words, four pixels per three words.
// Optional per-line pixel count check is compiled in with `define PACKER_LINE_CHECK_EN.
module rgb_word_packer #(
   parameter int PIXEL_WIDTH = 24,
   parameter int LINE_PIXELS = 640
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PIXEL_WIDTH-1:0] shade_in,
   input  logic                   valid_in,
   input  logic                   sof_in,
   input  logic                   eol_in,
   output logic                   ready_out,
   output logic [31:0]            m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tuser,
   output logic                   m_tlast,
   output logic                   sync_err,
   output logic                   line_err
);

   logic [1:0]  r_ph;
   logic [23:0] r_res;
   logic        r_flush_pend;
   logic        r_sof_pend;
   logic        r_sync_err;
   logic        r_tvalid;
   logic [31:0] r_tdata;
   logic        r_tuser;
   logic        r_tlast;

   logic [23:0] w_pix;
   logic        w_free;
   logic        w_acc;
   logic [1:0]  w_ph_eff;
   logic [1:0]  w_ph_nxt;
   logic        w_emit;
   logic [31:0] w_word;
   logic        w_last;
   logic        w_flush;
   logic [23:0] w_res_nxt;
   logic        w_load_data;
   logic        w_load_flush;
   logic        w_tuser;

   assign w_pix     = shade_in[23:0];
   assign w_free    = !r_tvalid || m_tready;
   assign ready_out = !rst && !r_flush_pend && w_free;
   assign w_acc     = valid_in && ready_out;

   // A start-of-frame pixel always restarts the group, discarding any residual bytes
   always_comb begin
      w_ph_eff  = sof_in ? 2'd0 : r_ph;
      w_emit    = 1'b0;
      w_word    = 32'h0;
      w_last    = 1'b0;
      w_flush   = 1'b0;
      w_res_nxt = r_res;
      case (w_ph_eff)
         2'd0: begin
            w_res_nxt = w_pix;
            if (eol_in) begin
               w_emit = 1'b1;
               w_word = {8'h00, w_pix};
               w_last = 1'b1;
            end
         end
         2'd1: begin
            w_emit    = 1'b1;
            w_word    = {w_pix[7:0], r_res};
            w_res_nxt = {8'h00, w_pix[23:8]};
            w_flush   = eol_in;
         end
         2'd2: begin
            w_emit    = 1'b1;
            w_word    = {w_pix[15:0], r_res[15:0]};
            w_res_nxt = {16'h0000, w_pix[23:16]};
            w_flush   = eol_in;
         end
         default: begin
            w_emit = 1'b1;
            w_word = {w_pix, r_res[7:0]};
            w_last = eol_in;
         end
      endcase
      w_ph_nxt = eol_in ? 2'd0 : w_ph_eff + 2'd1;
   end

   // Flush and data loads never coincide: ready_out is held low while a flush is pending
   assign w_load_data  = w_acc && w_emit;
   assign w_load_flush = r_flush_pend && w_free;
   assign w_tuser      = r_sof_pend || (w_acc && sof_in);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ph         <= 2'd0;
         r_res        <= 24'h0;
         r_flush_pend <= 1'b0;
         r_sof_pend   <= 1'b0;
         r_sync_err   <= 1'b0;
         r_tvalid     <= 1'b0;
         r_tdata      <= 32'h0;
         r_tuser      <= 1'b0;
         r_tlast      <= 1'b0;
      end else begin
         if (w_acc) begin
            r_ph  <= w_ph_nxt;
            r_res <= w_res_nxt;
            if (w_flush)
               r_flush_pend <= 1'b1;
            if (sof_in && (r_ph != 2'd0))
               r_sync_err <= 1'b1;
         end

         if (w_load_data) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_word;
            r_tlast  <= w_last;
            r_tuser  <= w_tuser;
         end else if (w_load_flush) begin
            r_tvalid     <= 1'b1;
            r_tdata      <= {8'h00, r_res};
            r_tlast      <= 1'b1;
            r_tuser      <= r_sof_pend;
            r_flush_pend <= 1'b0;
         end else if (m_tready) begin
            r_tvalid <= 1'b0;
         end

         if (w_load_data || w_load_flush)
            r_sof_pend <= 1'b0;
         else if (w_acc && sof_in)
            r_sof_pend <= 1'b1;
      end
   end

   assign m_tdata  = r_tdata;
   assign m_tvalid = r_tvalid;
   assign m_tuser  = r_tuser;
   assign m_tlast  = r_tlast;
   assign sync_err = r_sync_err;

`ifdef PACKER_LINE_CHECK_EN
   localparam logic [10:0] LP_LAST = 11'(LINE_PIXELS - 1);

   logic [10:0] r_pix_cnt;
   logic        r_line_err;
   logic [10:0] w_idx;

   // w_idx is the position of the pixel being accepted within its line
   assign w_idx = sof_in ? 11'd0 : r_pix_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix_cnt  <= 11'd0;
         r_line_err <= 1'b0;
      end else if (w_acc) begin
         if (eol_in) begin
            r_pix_cnt <= 11'd0;
            if (w_idx != LP_LAST)
               r_line_err <= 1'b1;
         end else begin
            r_pix_cnt <= w_idx + 11'd1;
            if (w_idx == LP_LAST)
               r_line_err <= 1'b1;
         end
      end
   end

   assign line_err = r_line_err;
`else
   logic [10:0] w_unused_line_pixels;
   assign w_unused_line_pixels = 11'(LINE_PIXELS);
   assign line_err = 1'b0;
`endif

endmodule
